// File: rtl/key_play_ctrl_if.sv
// Front-panel bus between the raw buttons, the transport control stage and the player.
interface key_play_ctrl_if;
  logic       key_play_in;
  logic       key_stop_in;
  logic       en;
  logic       key;
  logic       clr_n;
  logic [1:0] state;

  modport master (output key_play_in, key_stop_in, input en, key, clr_n, state);
  modport slave  (input key_play_in, key_stop_in, output en, key, clr_n, state);
endinterface

// File: rtl/key_play_ctrl.sv
// Button debounce + STOP/PLAY/PAUSE transport FSM feeding the music player's en/key/clr_n.
// Optional long-press-to-stop on the play key: define KEY_PLAY_CTRL_LONG_PRESS_EN.
module key_play_ctrl_db #(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic fall
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      cnt      <= '0;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      fall     <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == stable)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        stable <= sync[1];
        cnt    <= '0;
      end else
        cnt <= cnt + 1'b1;
      // Edge taken from the delayed copy so the pulse lands one cycle after stable moves.
      stable_d <= stable;
      fall     <= stable_d & ~stable;
    end
  end
endmodule

module key_play_ctrl #(
  parameter int DEBOUNCE   = 1_000_000,
  parameter int LONG_PRESS = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  key_play_ctrl_if.slave     bus
);
  localparam int NUM_KEYS = 2;
  localparam int KEY_PLAY = 0;
  localparam int KEY_STOP = 1;

  localparam logic [1:0] S_STOP  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] fall;
  logic                long_evt;
  logic                stop_act;
  logic [1:0]          state_q, state_n;
  logic                en_q, key_q, clr_n_q;

  assign raw_keys = {bus.key_stop_in, bus.key_play_in};

  key_play_ctrl_db #(.DEBOUNCE(DEBOUNCE)) u_db [NUM_KEYS-1:0] (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw_keys),
    .stable (stable),
    .fall   (fall)
  );

`ifdef KEY_PLAY_CTRL_LONG_PRESS_EN
  localparam int HW = (LONG_PRESS > 1) ? $clog2(LONG_PRESS) : 1;
  logic [HW-1:0] hold_cnt;
  logic          unused_stop_stable;

  // Counter parks at LONG_PRESS-1 so a single hold fires exactly once.
  always_ff @(posedge clk) begin
    if (rst || stable[KEY_PLAY])
      hold_cnt <= '0;
    else if (hold_cnt != HW'(LONG_PRESS - 1))
      hold_cnt <= hold_cnt + 1'b1;
  end

  assign long_evt           = ~stable[KEY_PLAY] & (hold_cnt == HW'(LONG_PRESS - 2));
  assign unused_stop_stable = stable[KEY_STOP];
`else
  logic unused_long_press;
  assign long_evt          = 1'b0;
  assign unused_long_press = (LONG_PRESS > 0) | (^stable);
`endif

  assign stop_act = fall[KEY_STOP] | long_evt;

  always_comb begin
    state_n = state_q;
    if (stop_act)
      state_n = S_STOP;
    else if (fall[KEY_PLAY]) begin
      case (state_q)
        S_STOP:  state_n = S_PLAY;
        S_PLAY:  state_n = S_PAUSE;
        S_PAUSE: state_n = S_PLAY;
        default: state_n = S_STOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_STOP;
      en_q    <= 1'b0;
      key_q   <= 1'b0;
      clr_n_q <= 1'b0;
    end else begin
      state_q <= state_n;
      en_q    <= (state_n == S_PLAY);
      key_q   <= (state_n == S_PLAY);
      clr_n_q <= ~stop_act;
    end
  end

  assign bus.state = state_q;
  assign bus.en    = en_q;
  assign bus.key   = key_q;
  assign bus.clr_n = clr_n_q;
endmodule

// File: tb/tb_key_play_ctrl.sv
// Directed bench for key_play_ctrl with DEBOUNCE=8, LONG_PRESS=32.
module tb_key_play_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  key_play_ctrl_if bus ();

  key_play_ctrl #(.DEBOUNCE(8), .LONG_PRESS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int en_e, input int clr_e);
    chk({tag, ".state"}, int'(bus.state), st);
    chk({tag, ".en"},    int'(bus.en),    en_e);
    chk({tag, ".key"},   int'(bus.key),   en_e);
    chk({tag, ".clr_n"}, int'(bus.clr_n), clr_e);
  endtask

  // Full play press: 20 cycles low, then release and let it settle.
  task automatic play_press();
    bus.key_play_in = 1'b0;
    tick(20);
    bus.key_play_in = 1'b1;
    tick(14);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_cnt;
    int saw_play;
    bus.key_play_in = 1'b1;
    bus.key_stop_in = 1'b1;

    // Reset
    tick(3);
    chk_out("reset", 0, 0, 0);
    rst = 1'b0;
    tick(1);
    chk_out("post_reset", 0, 0, 1);

    // Play press: PLAY exactly 12 edges after first low sample
    bus.key_play_in = 1'b0;
    tick(11);
    chk_out("play_e11", 0, 0, 1);
    tick(1);
    chk_out("play_e12", 1, 1, 1);
    tick(8);
    bus.key_play_in = 1'b1;
    tick(14);
    chk_out("play_held", 1, 1, 1);
    play_press();
    chk_out("pause", 2, 0, 1);
    play_press();
    chk_out("resume", 1, 1, 1);

    // Glitch of 7 cycles must be ignored
    clr_cnt = 0;
    bus.key_play_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (bus.clr_n === 1'b0) clr_cnt++;
    end
    bus.key_play_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.clr_n === 1'b0) clr_cnt++;
    end
    chk("glitch.clr_pulses", clr_cnt, 0);
    chk_out("glitch", 1, 1, 1);

    // Stop from PLAY: clr_n low one cycle, coincident with STOP
    bus.key_stop_in = 1'b0;
    tick(11);
    chk_out("stop_e11", 1, 1, 1);
    tick(1);
    chk_out("stop_e12", 0, 0, 0);
    tick(1);
    chk_out("stop_e13", 0, 0, 1);
    tick(7);
    bus.key_stop_in = 1'b1;
    tick(14);

    // Simultaneous press from PAUSE
    play_press();
    play_press();
    chk_out("pre_simul", 2, 0, 1);
    clr_cnt  = 0;
    saw_play = 0;
    bus.key_play_in = 1'b0;
    bus.key_stop_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (bus.clr_n === 1'b0) clr_cnt++;
      if (bus.state === 2'd1) saw_play = 1;
      if (i == 12) chk_out("simul_e12", 0, 0, 0);
    end
    chk("simul.clr_pulses", clr_cnt, 1);
    chk("simul.saw_play", saw_play, 0);
    bus.key_play_in = 1'b1;
    bus.key_stop_in = 1'b1;
    tick(14);
    chk_out("simul_end", 0, 0, 1);

    // Stop while already stopped still clears once
    clr_cnt = 0;
    bus.key_stop_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.clr_n === 1'b0) clr_cnt++;
    end
    bus.key_stop_in = 1'b1;
    tick(14);
    chk("stop_in_stop.clr_pulses", clr_cnt, 1);
    chk_out("stop_in_stop", 0, 0, 1);

    // Long hold of play for 60 cycles
    bus.key_play_in = 1'b0;
    tick(12);
    chk_out("long_e12", 1, 1, 1);
    tick(28);
    chk_out("long_e40", 1, 1, 1);
    tick(1);
`ifdef KEY_PLAY_CTRL_LONG_PRESS_EN
    chk_out("long_e41", 0, 0, 0);
`else
    chk_out("long_e41", 1, 1, 1);
`endif
    clr_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      tick(1);
      if (bus.clr_n === 1'b0) clr_cnt++;
    end
    chk("long.extra_clr", clr_cnt, 0);
    bus.key_play_in = 1'b1;
    tick(14);
`ifdef KEY_PLAY_CTRL_LONG_PRESS_EN
    chk_out("long_release", 0, 0, 1);
`else
    chk_out("long_release", 1, 1, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
